reg_writeback_unit: RTL and testbench

// Writer side of the 32x32 register file: accepts retiring results from the datapath, holds them in a
// one-entry writeback buffer, and drives the RF write port (rd, rd_din, write_enable) one cycle later.

---
 rtl/reg_writeback_unit_pkg.sv | 10 +
 rtl/reg_writeback_unit_if.sv | 12 +
 rtl/reg_writeback_unit.sv | 70 +++++++
 tb/tb_reg_writeback_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/reg_writeback_unit_pkg.sv
// reg_writeback_unit_pkg: shared widths, halt constants and FSM encodings
package reg_writeback_unit_pkg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam logic [RA_W-1:0] HALT_REG  = 5'd17;
    localparam logic [XLEN-1:0] HALT_CODE = 32'd10;
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
endpackage

// File: rtl/reg_writeback_unit_if.sv
// reg_writeback_unit_if: retiring-result handshake between result mux and writeback unit
interface reg_writeback_unit_if;
    import reg_writeback_unit_pkg::*;
    logic            wb_valid;
    logic            wb_ready;
    logic [RA_W-1:0] wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_data;
    logic            wb_is_ecall;
    modport master (output wb_valid, wb_rd, wb_reg_write, wb_data, wb_is_ecall, input wb_ready);
    modport slave  (input wb_valid, wb_rd, wb_reg_write, wb_data, wb_is_ecall, output wb_ready);
endinterface

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: one-entry writeback buffer driving the RF write port, with bypass and ecall halt
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    reg_writeback_unit_if.slave  wb,
    input  logic [RA_W-1:0]      rs1,
    input  logic [RA_W-1:0]      rs2,
    output logic                 rs1_fwd,
    output logic                 rs2_fwd,
    output logic [XLEN-1:0]      fwd_data,
    output logic [RA_W-1:0]      rf_rd,
    output logic [XLEN-1:0]      rf_rd_din,
    output logic                 rf_write_enable,
    output logic                 is_halted,
    output logic [XLEN-1:0]      retire_count
);
    logic [1:0]      state_q, state_d;
    logic            pv_q, pwe_q;
    logic [RA_W-1:0] prd_q;
    logic [XLEN-1:0] pdata_q, shadow_q, shadow_d, count_q, count_d;
    logic            xfer, commit, hit17;
    logic [XLEN-1:0] x17_eff;

    assign wb.wb_ready     = state_q == ST_RUN;
    assign is_halted       = state_q == ST_HALTED;
    assign rf_write_enable = commit;
    assign rf_rd           = prd_q;
    assign rf_rd_din       = pdata_q;
    assign fwd_data        = pdata_q;
    assign retire_count    = count_q;

    // Handshake, commit/bypass compares and next-state; the pending x17 write is visible to an ecall in the same cycle
    always_comb begin
        xfer     = wb.wb_valid & wb.wb_ready;
        commit   = pv_q & pwe_q & (prd_q != '0);
        hit17    = pv_q & pwe_q & (prd_q == HALT_REG);
        rs1_fwd  = commit & (prd_q == rs1);
        rs2_fwd  = commit & (prd_q == rs2);
        x17_eff  = hit17 ? pdata_q : shadow_q;
        shadow_d = hit17 ? pdata_q : shadow_q;
        count_d  = xfer ? count_q + 1'b1 : count_q;
        state_d  = (state_q != ST_RUN) ? ST_HALTED :
                   (xfer & wb.wb_is_ecall & (x17_eff == HALT_CODE)) ? ST_DRAIN : ST_RUN;
    end

    // Buffer reloads on every transfer and empties otherwise; the old entry commits at that same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pv_q     <= 1'b0;
            pwe_q    <= 1'b0;
            prd_q    <= '0;
            pdata_q  <= '0;
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pv_q     <= xfer;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            if (xfer) begin
                pwe_q   <= wb.wb_reg_write & ~wb.wb_is_ecall;
                prd_q   <= wb.wb_rd;
                pdata_q <= wb.wb_data;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: scoreboard bench for the writeback buffer, bypass, halt and retire counter
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    typedef struct {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0;
    logic        rs1_fwd, rs2_fwd, rf_write_enable, is_halted;
    logic [31:0] fwd_data, rf_rd_din, retire_count;
    logic [4:0]  rf_rd;
    int          checks = 0, fails = 0;
    int          m_state = 0;
    logic [31:0] m_count = '0, m_x17 = '0;
    bit          par = 1'b0;
    exp_t        q[$];

    always #5 clk = ~clk;

    reg_writeback_unit_if wb();

    reg_writeback_unit dut (
        .clk(clk), .reset(reset), .wb(wb.slave), .rs1(rs1), .rs2(rs2),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data),
        .rf_rd(rf_rd), .rf_rd_din(rf_rd_din), .rf_write_enable(rf_write_enable),
        .is_halted(is_halted), .retire_count(retire_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wb.wb_valid = 0; wb.wb_rd = '0; wb.wb_reg_write = 0; wb.wb_data = '0; wb.wb_is_ecall = 0;
        #1;
        chk("rst_we", rf_write_enable, 0);
        chk("rst_rd", rf_rd, 0);
        chk("rst_din", rf_rd_din, 0);
        chk("rst_fwd", {rs1_fwd, rs2_fwd}, 0);
        chk("rst_ready", wb.wb_ready, 1);
        chk("rst_halted", is_halted, 0);
        chk("rst_count", retire_count, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        m_state = 0; m_count = '0; m_x17 = '0;
        q.delete();
    endtask

    task automatic step(input logic v, input logic [4:0] rd, input logic rw, input logic [31:0] d, input logic ec);
        exp_t e, p;
        logic x;
        wb.wb_valid = v; wb.wb_rd = rd; wb.wb_reg_write = rw; wb.wb_data = d; wb.wb_is_ecall = ec;
        x = v && m_state == 0;
        e.en = x && rw && !ec && rd != 0;
        e.rd = rd;
        e.d = d;
        q.push_back(e);
        @(posedge clk); #1;
        p = q.pop_front();
        chk("rf_we", rf_write_enable, p.en);
        if (p.en) begin
            chk("rf_rd", rf_rd, p.rd);
            chk("rf_din", rf_rd_din, p.d);
        end
        par = ~par;
        rs1 = par ? p.rd : p.rd ^ 5'd1;
        rs2 = par ? p.rd ^ 5'd1 : p.rd;
        #1;
        chk("rs1_fwd", rs1_fwd, par & p.en);
        chk("rs2_fwd", rs2_fwd, ~par & p.en);
        if (p.en) chk("fwd_data", fwd_data, p.d);
        if (m_state == 1) m_state = 2;
        else if (x) begin
            m_count++;
            if (ec && m_x17 == 32'd10) m_state = 1;
            if (e.en && rd == 5'd17) m_x17 = d;
        end
        chk("wb_ready", wb.wb_ready, m_state == 0);
        chk("halted", is_halted, m_state == 2);
        chk("count", retire_count, m_count);
    endtask

    initial begin
        do_reset();
        step(1, 5, 1, 32'h1234, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 32'hFFFF_FFFF, 0);
        step(0, 0, 0, 0, 0);
        step(1, 17, 1, 32'd10, 0);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 5'(i + 3), 1, 32'h55 + i, 0);
        do_reset();
        step(1, 17, 1, 32'd9, 0);
        step(1, 0, 0, 0, 1);
        step(1, 17, 1, 32'd10, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 5'd9, 1, 32'hDEAD, 0);
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 1, 32'hA0 + i, 0);
        step(0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? 32'd10 : $urandom, 1'($urandom_range(0, 9) == 0));
        do_reset();
        step(1, 7, 1, 32'h77, 0);
        rs1 = 5'd7;
        do_reset();
        step(0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
